float_divider: RTL
==================

// Module: float_divider
// PURPOSE
//  IEEE-754 single-precision divider: z = a / b. Pairs with the FP multiplier in the compute datapath
//  and uses the same stb/ack handshake. Both operands are captured together, the mantissa is divided
//  iteratively one quotient bit per cycle, and the result is rounded round-to-nearest-even.
// PARAMETERS
//  (none) format fixed to binary32; constants come from fp32_pkg
// PORTS
//  clk           in   1   rising-edge clock; the only clock
//  rst_n         in   1   reset, asynchronous, active-low
//  input_a       in   32  dividend
//  input_b       in   32  divisor
//  input_stb     in   1   operands valid
//  input_ack     out  1   divider ready to accept operands
//  output_z      out  32  quotient
//  output_z_stb  out  1   quotient valid
//  output_z_ack  in   1   consumer has taken quotient
// BEHAVIOUR
//  - Reset (rst_n=0, any state, mid-division included): abort. State=GET; input_ack=0, output_z_stb=0,
//    output_z=0. input_ack rises on the first clock after rst_n deasserts.
//  - Input handshake: input_ack=1 only in GET. Transfer happens when input_stb&&input_ack are high at a
//    clock edge. input_ack drops on the next cycle.
//  - Output handshake: in PUT, output_z_stb=1 and output_z is held stable until output_z_ack=1 at an
//    edge. stb then drops and the FSM returns to GET. A new operand transfer takes at least 1 cycle.
//  - FSM: GET->UNPACK->SPECIAL->{PUT | NORM_A->NORM_B->DIV_0->DIV_1(x50)->DIV_2->NORM_1->NORM_2
//    ->ROUND->PACK->PUT}
//  - UNPACK: m=frac (23b), e=exp-127 as signed 10b, s=sign.
//  - SPECIAL, checked in priority order:
//    - a or b NaN -> 0xFFC00000
//    - inf/inf -> 0xFFC00000
//    - 0/0 -> 0xFFC00000
//    - inf/x -> inf, sign a_s^b_s
//    - x/0 -> inf, sign a_s^b_s
//    - 0/x -> signed zero
//    - x/inf -> signed zero
//    - otherwise: a denormal gets e=-126; a normal gets hidden bit m[23]=1 (same for b).
//  - NORM_A/B: shift m left and decrement e until m[23]=1. Takes 1 cycle per bit, up to 23 each.
//  - DIV_0: z_s=a_s^b_s; z_e=a_e-b_e; dividend={a_m,27'b0} (51b); divisor={b_m,27'b0}; quotient=0.
//  - DIV_1: restoring division, 50 iterations, 1 quotient bit per cycle.
//  - DIV_2: z_m=q[26:3]; guard=q[2]; round=q[1]; sticky=q[0]|(remainder!=0).
//  - NORM_1: while z_m[23]==0, shift left and pull in guard; z_e--.
//  - NORM_2: while z_e<-126, shift right; z_e++; guard/round/sticky collect the shifted-out bits.
//  - ROUND: RNE. Increment if guard&&(round|sticky|z_m[0]). A carry out of 0xFFFFFF increments z_e.
//  - PACK: biased exp=z_e+127. If z_e==-126 and z_m[23]==0, emit a denormal (exp=0).
//    If z_e>127, emit inf with sign z_s.
//  - Latency, accept edge -> output_z_stb high: 3 cycles for special cases; at most 130 cycles
//    for normal operands.
// CONFIGURATION
//  FDIV_FLAGS_EN defined:
//    - adds port output_z_flags out 5 = {invalid, div_by_zero, overflow, underflow, inexact}.
//    - Flags are valid with output_z_stb and reset to 0.
//    - div_by_zero: finite nonzero / 0.
//    - invalid: every case that returns NaN.
//    - inexact: guard|round|sticky at ROUND, or overflow.
//    - underflow: result is tiny and inexact.
//  FDIV_FLAGS_EN undefined: the port is absent. Quotient results are bit-identical in both builds.
// STRUCTURE
//  - fp32_pkg: state encodings; FP32_BIAS=127; FP32_EMAX=128; FP32_EMIN=-126;
//    FP32_QNAN=32'hFFC00000; FP32_INF=8'hFF; flag bit indices.
//  - Sub-module fdiv_mant_core: owns the 51-bit restoring quotient/remainder iteration.
//    Interface: start pulse, a_m/b_m in; done, quotient, rem_nz out.
// TESTING
//  - 0x40C00000 / 0x40000000 (6/2) -> 0x40400000; flags 0
//  - 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB; inexact=1
//  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1
//  - 0x00000000 / 0x00000000 -> 0xFFC00000, invalid=1
//  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow=1
//  - 0x00000001 / 0x40000000 (tie) -> 0x00000000, underflow=1
//  - 0x00800000 / 0x40000000 -> 0x00400000 (exact denormal), flags 0
//  - Hold output_z_ack=0 for 10 cycles: stb and z stay stable, input_ack stays 0.
//    Pulse ack: stb drops next cycle, input_ack rises the cycle after.
//  - Drop rst_n during DIV_1: all outputs 0 immediately. After release, 6/2 completes correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 constants, divider FSM states and flag indices.
// Shared by float_divider and fdiv_mant_core.
package fp32_pkg;

  localparam logic signed [9:0] FP32_BIAS  = 10'sd127;
  localparam logic signed [9:0] FP32_EMAX  = 10'sd128;
  localparam logic signed [9:0] FP32_EMIN  = -10'sd126;
  localparam logic signed [9:0] FP32_EZERO = -10'sd127;
  localparam logic [31:0]       FP32_QNAN  = 32'hFFC00000;
  localparam logic [7:0]        FP32_INF   = 8'hFF;

  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  typedef enum logic [3:0] {
    ST_GET,
    ST_UNPACK,
    ST_SPECIAL,
    ST_NORM_A,
    ST_NORM_B,
    ST_DIV_0,
    ST_DIV_1,
    ST_DIV_2,
    ST_NORM_1,
    ST_NORM_2,
    ST_ROUND,
    ST_PACK,
    ST_PUT
  } fdiv_state_t;

endpackage

// File: rtl/fdiv_mant_core.sv
// fdiv_mant_core: restoring mantissa divider, one quotient bit per cycle.
// Computes floor((a_m << 26) / b_m) over 50 iterations after a start pulse.
module fdiv_mant_core
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] a_m,
  input  logic [23:0] b_m,
  output logic        done,
  output logic [26:0] quotient,
  output logic        rem_nz
);

  logic [50:0] dividend;
  logic [23:0] divisor;
  logic [24:0] remainder;
  logic [5:0]  count;
  logic        busy;
  logic [24:0] rem_sh;
  logic        rem_ge;

  // ratio a_m/b_m < 2, so only the low 27 quotient bits can be set
  always_comb begin
    rem_sh = {remainder[23:0], dividend[50]};
    rem_ge = rem_sh >= {1'b0, divisor};
  end

  assign done   = busy && (count == 6'd49);
  assign rem_nz = |remainder;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend  <= '0;
      divisor   <= '0;
      remainder <= '0;
      quotient  <= '0;
      count     <= '0;
      busy      <= 1'b0;
    end else if (start) begin
      dividend  <= {a_m, 27'd0};
      divisor   <= b_m;
      remainder <= '0;
      quotient  <= '0;
      count     <= '0;
      busy      <= 1'b1;
    end else if (busy) begin
      dividend  <= {dividend[49:0], 1'b0};
      remainder <= rem_ge ? rem_sh - {1'b0, divisor}
                          : rem_sh;
      quotient  <= {quotient[25:0], rem_ge};
      count     <= count + 6'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/float_divider.sv
// float_divider: binary32 z = a / b, round-to-nearest-even, stb/ack handshake.
// Define FDIV_FLAGS_EN to add the output_z_flags exception port.
module float_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_stb,
  output logic        input_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
`ifdef FDIV_FLAGS_EN
  output logic [4:0]  output_z_flags,
`endif
  input  logic        output_z_ack
);

  fdiv_state_t state;

  logic [31:0] a, b;
  logic        a_s, b_s, z_s;
  logic signed [9:0] a_e, b_e, z_e;
  logic [23:0] a_m, b_m, z_m;
  logic        guard, round_bit, sticky;
`ifdef FDIV_FLAGS_EN
  logic        inexact_r;
`endif

  logic        core_start;
  logic        core_done;
  logic [26:0] core_q;
  logic        core_rem_nz;

  logic        a_nan, b_nan;
  logic        a_inf, b_inf;
  logic        a_zero, b_zero;
  logic        z_sg;
  logic [9:0]  dn_amt;
  logic [4:0]  dn_k;
  logic [51:0] dn_w;

  assign core_start = (state == ST_DIV_0);

  fdiv_mant_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .a_m      (a_m),
    .b_m      (b_m),
    .done     (core_done),
    .quotient (core_q),
    .rem_nz   (core_rem_nz)
  );

  always_comb begin
    a_nan  = (a_e == FP32_EMAX) && (|a_m[22:0]);
    b_nan  = (b_e == FP32_EMAX) && (|b_m[22:0]);
    a_inf  = (a_e == FP32_EMAX) && !(|a_m[22:0]);
    b_inf  = (b_e == FP32_EMAX) && !(|b_m[22:0]);
    a_zero = (a_e == FP32_EZERO) && !(|a_m[22:0]);
    b_zero = (b_e == FP32_EZERO) && !(|b_m[22:0]);
    z_sg   = a_s ^ b_s;
  end

  // Denormalising shift done in one step; past 26 places
  // every bit of {z_m,guard,round} lands in sticky.
  always_comb begin
    dn_amt = FP32_EMIN - z_e;
    dn_k   = (dn_amt > 10'd26) ? 5'd26 : dn_amt[4:0];
    dn_w   = {z_m, guard, round_bit, 26'd0} >> dn_k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GET;
      input_ack    <= 1'b0;
      output_z     <= '0;
      output_z_stb <= 1'b0;
      a            <= '0;
      b            <= '0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      a_e          <= '0;
      b_e          <= '0;
      z_e          <= '0;
      a_m          <= '0;
      b_m          <= '0;
      z_m          <= '0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
`ifdef FDIV_FLAGS_EN
      inexact_r      <= 1'b0;
      output_z_flags <= '0;
`endif
    end else begin
      unique case (state)
        ST_GET: begin
          input_ack <= 1'b1;
          if (input_ack && input_stb) begin
            a         <= input_a;
            b         <= input_b;
            input_ack <= 1'b0;
            state     <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          a_m   <= {1'b0, a[22:0]};
          b_m   <= {1'b0, b[22:0]};
          a_e   <= $signed({2'b00, a[30:23]}) - FP32_BIAS;
          b_e   <= $signed({2'b00, b[30:23]}) - FP32_BIAS;
          a_s   <= a[31];
          b_s   <= b[31];
          state <= ST_SPECIAL;
        end
        ST_SPECIAL: begin
`ifdef FDIV_FLAGS_EN
          output_z_flags <= '0;
`endif
          if (a_nan || b_nan || (a_inf && b_inf)
              || (a_zero && b_zero)) begin
            output_z     <= FP32_QNAN;
            output_z_stb <= 1'b1;
            state        <= ST_PUT;
`ifdef FDIV_FLAGS_EN
            output_z_flags[FLG_INV] <= 1'b1;
`endif
          end else if (a_inf || b_zero) begin
            output_z     <= {z_sg, FP32_INF, 23'd0};
            output_z_stb <= 1'b1;
            state        <= ST_PUT;
`ifdef FDIV_FLAGS_EN
            output_z_flags[FLG_DZ] <= !a_inf;
`endif
          end else if (a_zero || b_inf) begin
            output_z     <= {z_sg, 31'd0};
            output_z_stb <= 1'b1;
            state        <= ST_PUT;
          end else begin
            if (a_e == FP32_EZERO) a_e <= FP32_EMIN;
            else                   a_m[23] <= 1'b1;
            if (b_e == FP32_EZERO) b_e <= FP32_EMIN;
            else                   b_m[23] <= 1'b1;
            state <= ST_NORM_A;
          end
        end
        ST_NORM_A: begin
          if (a_m[23]) begin
            state <= ST_NORM_B;
          end else begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
          end
        end
        ST_NORM_B: begin
          if (b_m[23]) begin
            state <= ST_DIV_0;
          end else begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
          end
        end
        ST_DIV_0: begin
          z_s   <= z_sg;
          z_e   <= a_e - b_e;
          state <= ST_DIV_1;
        end
        ST_DIV_1: begin
          if (core_done) state <= ST_DIV_2;
        end
        ST_DIV_2: begin
          z_m       <= core_q[26:3];
          guard     <= core_q[2];
          round_bit <= core_q[1];
          sticky    <= core_q[0] | core_rem_nz;
          state     <= ST_NORM_1;
        end
        ST_NORM_1: begin
          if (!z_m[23]) begin
            z_m       <= {z_m[22:0], guard};
            z_e       <= z_e - 10'sd1;
            guard     <= round_bit;
            round_bit <= 1'b0;
          end else begin
            state <= ST_NORM_2;
          end
        end
        ST_NORM_2: begin
          if (z_e < FP32_EMIN) begin
            z_m       <= dn_w[51:28];
            guard     <= dn_w[27];
            round_bit <= dn_w[26];
            sticky    <= sticky | (|dn_w[25:0]);
            z_e       <= FP32_EMIN;
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            if (z_m == 24'hFFFFFF) begin
              z_m <= 24'h800000;
              z_e <= z_e + 10'sd1;
            end else begin
              z_m <= z_m + 24'd1;
            end
          end
`ifdef FDIV_FLAGS_EN
          inexact_r <= guard | round_bit | sticky;
`endif
          state <= ST_PACK;
        end
        ST_PACK: begin
          output_z_stb <= 1'b1;
          state        <= ST_PUT;
`ifdef FDIV_FLAGS_EN
          output_z_flags         <= '0;
          output_z_flags[FLG_NX] <= inexact_r;
`endif
          if (z_e >= FP32_EMAX) begin
            output_z <= {z_s, FP32_INF, 23'd0};
`ifdef FDIV_FLAGS_EN
            output_z_flags[FLG_OVF] <= 1'b1;
            output_z_flags[FLG_NX]  <= 1'b1;
`endif
          end else if (z_e == FP32_EMIN && !z_m[23]) begin
            output_z <= {z_s, 8'd0, z_m[22:0]};
`ifdef FDIV_FLAGS_EN
            output_z_flags[FLG_UNF] <= inexact_r;
`endif
          end else begin
            output_z <= {z_s, 8'(z_e + FP32_BIAS), z_m[22:0]};
          end
        end
        ST_PUT: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= ST_GET;
          end
        end
        default: state <= ST_GET;
      endcase
    end
  end

endmodule
